// File: rtl/dcache_miss_ctrl.sv
// rtl/dcache_miss_ctrl.sv - D-cache miss sequencer: dirty-victim writeback then word-by-word line fill
module dcache_miss_ctrl #(
    parameter int ADDR_W     = 32,
    parameter int LINE_WORDS = 4,
    parameter int IDX_W      = 2
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              FREEZE,
    input  logic              flush,
    input  logic              head_req,
    input  logic [ADDR_W-1:0] head_addr,
    input  logic              tag_hit,
    input  logic              victim_dirty,
    input  logic [ADDR_W-1:0] victim_addr,
    output logic              DMISS,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    output logic [IDX_W-1:0]  wb_rd_idx,
    output logic              fill_we,
    output logic [IDX_W-1:0]  fill_idx,
    output logic              fill_done,
    output logic [15:0]       miss_cnt
);

    localparam int OFF = IDX_W + 2;
    localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WB   = 2'd1,
        S_FILL = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [IDX_W-1:0]  beat;
    logic [IDX_W-1:0]  beat_nxt;
    logic [ADDR_W-1:0] fill_base;
    logic [ADDR_W-1:0] wb_base;
    logic [ADDR_W-1:0] beat_off;
    logic              head_miss;
    logic              miss_start;

    // The line transaction always runs to completion, so flush has nothing to act on;
    // the line-offset bits of head_addr are discarded when the fill base is formed.
    logic unused_inputs;
    assign unused_inputs = ^{flush, head_addr[OFF-1:0]};

    assign head_miss  = head_req & ~tag_hit;
    assign miss_start = (state == S_IDLE) & head_miss & ~FREEZE;
    assign beat_off   = {{(ADDR_W - OFF){1'b0}}, beat, 2'b00};

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state     <= S_IDLE;
            beat      <= '0;
            miss_cnt  <= '0;
            fill_base <= '0;
            wb_base   <= '0;
        end else if (!FREEZE) begin
            state <= state_nxt;
            beat  <= beat_nxt;
            if (miss_start) begin
                miss_cnt  <= miss_cnt + 16'd1;
                fill_base <= {head_addr[ADDR_W-1:OFF], {OFF{1'b0}}};
                wb_base   <= victim_addr;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        beat_nxt  = beat;
        DMISS     = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        wb_rd_idx = '0;
        fill_we   = 1'b0;
        fill_idx  = '0;
        fill_done = 1'b0;

        case (state)
            S_IDLE: begin
                // Combinational here so the missing head is blocked in the very cycle it misses.
                DMISS = head_miss;
                if (head_miss) begin
                    beat_nxt  = '0;
                    state_nxt = victim_dirty ? S_WB : S_FILL;
                end
            end
            S_WB: begin
                DMISS     = 1'b1;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = wb_base + beat_off;
                wb_rd_idx = beat;
                if (mem_ack) begin
                    if (beat == LAST_BEAT) begin
                        beat_nxt  = '0;
                        state_nxt = S_FILL;
                    end else begin
                        beat_nxt = beat + IDX_W'(1);
                    end
                end
            end
            S_FILL: begin
                DMISS    = 1'b1;
                mem_req  = 1'b1;
                mem_addr = fill_base + beat_off;
                fill_idx = beat;
                fill_we  = mem_ack & ~FREEZE;
                if (mem_ack) begin
                    if (beat == LAST_BEAT) begin
                        beat_nxt  = '0;
                        state_nxt = S_DONE;
                    end else begin
                        beat_nxt = beat + IDX_W'(1);
                    end
                end
            end
            S_DONE: begin
                DMISS     = 1'b1;
                fill_done = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // Keep every output quiet while reset is held, whatever the head is presenting.
        if (!RESET) begin
            DMISS     = 1'b0;
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            mem_addr  = '0;
            wb_rd_idx = '0;
            fill_we   = 1'b0;
            fill_idx  = '0;
            fill_done = 1'b0;
        end
    end

endmodule
